// File: rtl/phy_tx_arbiter_if.sv
// Handshake bundle between the switch output requesters, the TX lane arbiter and the TX PHY manager.
// slave = arbiter view, master = requester/PHY-manager view.
interface phy_tx_arbiter_if #(
    parameter int NPORTS = 4,
    parameter int FLIT_W = 32
);
    localparam int OWN_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [NPORTS-1:0]        in_data_ready;
    logic [NPORTS*FLIT_W-1:0] in_flit;
    logic [NPORTS-1:0]        in_last;
    logic [NPORTS-1:0]        in_buffer_full;
    logic                     out_data_ready;
    logic [FLIT_W-1:0]        out_flit;
    logic                     out_buffer_full;
    logic                     busy;
    logic [OWN_W-1:0]         owner;

    modport slave (
        input  in_data_ready, in_flit, in_last, out_buffer_full,
        output in_buffer_full, out_data_ready, out_flit, busy, owner
    );

    modport master (
        output in_data_ready, in_flit, in_last, out_buffer_full,
        input  in_buffer_full, out_data_ready, out_flit, busy, owner
    );
endinterface

// File: rtl/phy_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one PHY TX lane among NPORTS requesters.
// Define PHY_TX_ARB_OUT_REG_EN to drive out_data_ready/out_flit from a 1-entry output register.
module phy_tx_arbiter #(
    parameter int NPORTS = 4,
    parameter int FLIT_W = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    phy_tx_arbiter_if.slave bus
);
    localparam int OWN_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            r_state, w_state_nxt;
    logic [OWN_W-1:0]  r_owner, w_owner_nxt;
    logic [OWN_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic [OWN_W-1:0]  w_ptr_after, w_arb_ptr, w_win_idx, w_cand;
    logic [NPORTS-1:0] w_arb_req, w_in_bf;
    logic              w_win_found;
    logic              w_owner_req, w_owner_last, w_accept, w_xfer, w_tail;
    logic [FLIT_W-1:0] w_owner_flit;

    assign w_owner_req  = bus.in_data_ready[r_owner];
    assign w_owner_last = bus.in_last[r_owner];
    assign w_owner_flit = bus.in_flit[r_owner*FLIT_W +: FLIT_W];
    assign w_ptr_after  = (int'(r_owner) == NPORTS - 1) ? '0 : r_owner + 1'b1;

`ifdef PHY_TX_ARB_OUT_REG_EN
    logic              r_out_valid;
    logic [FLIT_W-1:0] r_out_flit;

    // Accept into the register when it is empty or draining this very cycle.
    assign w_accept = ~r_out_valid | ~bus.out_buffer_full;
`else
    assign w_accept = ~bus.out_buffer_full;
`endif

    assign w_xfer = (r_state == BUSY) & w_owner_req & w_accept;
    assign w_tail = w_xfer & w_owner_last;

    // Round-robin search; on a tail the old owner is masked and the search starts past it.
    always_comb begin
        w_arb_ptr = (r_state == BUSY) ? w_ptr_after : r_rr_ptr;
        w_arb_req = bus.in_data_ready;
        if (r_state == BUSY) begin
            w_arb_req[r_owner] = 1'b0;
        end
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            w_cand = OWN_W'((32'(w_arb_ptr) + i) % NPORTS);
            if (!w_win_found && w_arb_req[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_rr_ptr_nxt = r_rr_ptr;
        w_in_bf      = '1;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_owner_nxt = w_win_idx;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_in_bf[r_owner] = ~w_accept;
                if (w_tail) begin
                    w_rr_ptr_nxt = w_ptr_after;
                    if (w_win_found) begin
                        w_owner_nxt = w_win_idx;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    assign bus.in_buffer_full = w_in_bf;
    assign bus.owner          = r_owner;

`ifdef PHY_TX_ARB_OUT_REG_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_flit  <= w_owner_flit;
        end else if (!bus.out_buffer_full) begin
            r_out_valid <= 1'b0;
        end
    end

    // The lock is released at the register input, but the lane stays busy until the tail drains.
    assign bus.out_data_ready = r_out_valid;
    assign bus.out_flit       = r_out_flit;
    assign bus.busy           = (r_state == BUSY) | r_out_valid;
`else
    assign bus.out_data_ready = (r_state == BUSY) & w_owner_req;
    assign bus.out_flit       = (r_state == BUSY) ? w_owner_flit : '0;
    assign bus.busy           = (r_state == BUSY);
`endif
endmodule

// File: tb/tb_phy_tx_arbiter.sv
// Self-checking bench for phy_tx_arbiter: per-port source queues feed the DUT, a scoreboard
// queue holds the expected lane order and is popped on every lane transfer.
module tb_phy_tx_arbiter;
    localparam int NPORTS = 4;
    localparam int FLIT_W = 32;

`ifdef PHY_TX_ARB_OUT_REG_EN
    localparam int unsigned LAT = 2;
`else
    localparam int unsigned LAT = 1;
`endif

    typedef struct packed {
        logic              last;
        logic [FLIT_W-1:0] data;
    } src_t;

    logic CLK  = 1'b0;
    logic nRST = 1'b1;

    phy_tx_arbiter_if #(.NPORTS(NPORTS), .FLIT_W(FLIT_W)) bus ();

    phy_tx_arbiter #(.NPORTS(NPORTS), .FLIT_W(FLIT_W)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    src_t              src_q [NPORTS][$];
    logic [FLIT_W-1:0] exp_q [$];
    int unsigned       xfer_cyc [$];
    int unsigned       checks = 0;
    int unsigned       fails  = 0;
    int unsigned       n_xfer = 0;
    int unsigned       cyc    = 0;
    logic [NPORTS-1:0] fire_s = '0;
    logic [FLIT_W-1:0] mon_e;
    logic [5:0]        t1_dr, t1_busy;

    always @(posedge CLK) cyc <= cyc + 1;

    // Scoreboard: every lane transfer must match the next expected flit.
    always @(negedge CLK) begin
        fire_s = bus.in_data_ready & ~bus.in_buffer_full;
        if (nRST && bus.out_data_ready && !bus.out_buffer_full) begin
            n_xfer++;
            xfer_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_extra: got flit %h, expected no transfer", bus.out_flit);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.out_flit !== mon_e) begin
                    fails++;
                    $display("FAIL scoreboard_flit: got %h, expected %h", bus.out_flit, mon_e);
                end
            end
        end
    end

    task automatic drive_srcs();
        logic [NPORTS-1:0]        dr, lst;
        logic [NPORTS*FLIT_W-1:0] fl;
        dr  = '0;
        lst = '0;
        fl  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (fire_s[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
            if (src_q[p].size() > 0) begin
                dr[p]                 = 1'b1;
                lst[p]                = src_q[p][0].last;
                fl[p*FLIT_W +: FLIT_W] = src_q[p][0].data;
            end
        end
        fire_s            = '0;
        bus.in_data_ready = dr;
        bus.in_last       = lst;
        bus.in_flit       = fl;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        drive_srcs();
    endtask

    task automatic sample();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_all();
        for (int p = 0; p < NPORTS; p++) src_q[p].delete();
        exp_q.delete();
        xfer_cyc.delete();
        n_xfer = 0;
        fire_s = '0;
        drive_srcs();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        bus.out_buffer_full = 1'b0;
        clear_all();
        repeat (2) @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic push_pkt(input int p, input int n, input logic [FLIT_W-1:0] base);
        for (int k = 0; k < n; k++) begin
            src_q[p].push_back({(k == n - 1), base + FLIT_W'(k)});
            exp_q.push_back(base + FLIT_W'(k));
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        bus.out_buffer_full = 1'b0;
        clear_all();
        bus.in_data_ready = '1;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.out_data_ready !== 1'b0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctrl: out_data_ready=%b busy=%b, expected 0 0", bus.out_data_ready, bus.busy);
        end
        checks++;
        if (bus.in_buffer_full !== 4'b1111 || bus.out_flit !== 32'h0 || bus.owner !== 2'd0) begin
            fails++;
            $display("FAIL reset_vals: in_buffer_full=%b out_flit=%h owner=%0d, expected 1111 0 0",
                     bus.in_buffer_full, bus.out_flit, bus.owner);
        end
        bus.in_data_ready = '0;
    endtask

    task automatic test_single_packet();
        int unsigned start;
        int unsigned k;
`ifdef PHY_TX_ARB_OUT_REG_EN
        t1_dr   = 6'b011100;
        t1_busy = 6'b011110;
`else
        t1_dr   = 6'b001110;
        t1_busy = 6'b001110;
`endif
        do_reset();
        push_pkt(2, 3, 32'hA0);
        drive_srcs();
        start = cyc;
        for (int c = 0; c < 6; c++) begin
            sample();
            checks++;
            if (bus.out_data_ready !== t1_dr[c] || bus.busy !== t1_busy[c]) begin
                fails++;
                $display("FAIL t1_timing c%0d: out_data_ready=%b busy=%b, expected %b %b",
                         c, bus.out_data_ready, bus.busy, t1_dr[c], t1_busy[c]);
            end
            if (c == 1) begin
                checks++;
                if (bus.owner !== 2'd2 || bus.in_buffer_full !== 4'b1011) begin
                    fails++;
                    $display("FAIL t1_owner: owner=%0d in_buffer_full=%b, expected 2 1011",
                             bus.owner, bus.in_buffer_full);
                end
            end
            tick();
        end
        checks++;
        if (n_xfer != 3 || xfer_cyc.size() != 3) begin
            fails++;
            $display("FAIL t1_count: %0d transfers, expected 3", n_xfer);
        end else if (xfer_cyc[0] != start + LAT || xfer_cyc[1] != xfer_cyc[0] + 1 || xfer_cyc[2] != xfer_cyc[1] + 1) begin
            fails++;
            $display("FAIL t1_cycles: transfers at %0d %0d %0d, expected %0d..%0d consecutive",
                     xfer_cyc[0], xfer_cyc[1], xfer_cyc[2], start + LAT, start + LAT + 2);
        end
        // rr_ptr is now 3: port 3 must win over port 0.
        push_pkt(3, 1, 32'h3000_0000);
        push_pkt(0, 1, 32'h0000_0000);
        drive_srcs();
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            tick();
            sample();
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || n_xfer != 5) begin
            fails++;
            $display("FAIL t1_rrptr: %0d outstanding, %0d transfers, expected 0 and 5", exp_q.size(), n_xfer);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned start;
        int unsigned k;
        bit gap;
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int p = 0; p < NPORTS; p++)
                push_pkt(p, 1, {8'(p), 16'h0, 8'(r)});
        drive_srcs();
        start = cyc;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            sample();
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || n_xfer != 12) begin
            fails++;
            $display("FAIL t2_drain: %0d outstanding, %0d transfers, expected 0 and 12", exp_q.size(), n_xfer);
        end
        gap = (xfer_cyc.size() != 12);
        if (!gap) begin
            for (int i = 1; i < 12; i++)
                if (xfer_cyc[i] != xfer_cyc[i-1] + 1) gap = 1'b1;
        end
        checks++;
        if (gap) begin
            fails++;
            $display("FAIL t2_bubbles: transfers not on 12 consecutive cycles, got %0d transfers", xfer_cyc.size());
        end else if (xfer_cyc[0] != start + LAT) begin
            fails++;
            checks++;
            $display("FAIL t2_first: first transfer at cycle %0d, expected %0d", xfer_cyc[0], start + LAT);
        end
    endtask

    task automatic test_lock();
        int unsigned k;
        do_reset();
        push_pkt(0, 4, 32'h0000_0100);
        drive_srcs();
        k = 0;
        while (n_xfer < 2 && k < 20) begin
            tick();
            sample();
            k++;
        end
        push_pkt(1, 2, 32'h1000_0100);
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            tick();
            sample();
            if (bus.busy && bus.owner == 2'd0 && bus.in_data_ready[1]) begin
                checks++;
                if (bus.in_buffer_full[1] !== 1'b1) begin
                    fails++;
                    $display("FAIL t3_stall: port1 in_buffer_full=%b while port0 owns, expected 1",
                             bus.in_buffer_full[1]);
                end
            end
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || xfer_cyc.size() != 6) begin
            fails++;
            $display("FAIL t3_drain: %0d outstanding, %0d transfers, expected 0 and 6", exp_q.size(), xfer_cyc.size());
        end else if (xfer_cyc[4] != xfer_cyc[3] + 1) begin
            fails++;
            $display("FAIL t3_handover: port1 head at %0d, expected %0d", xfer_cyc[4], xfer_cyc[3] + 1);
        end
    endtask

    task automatic test_backpressure();
        int unsigned k;
        logic [FLIT_W-1:0] held;
        do_reset();
        push_pkt(3, 6, 32'h3000_0200);
        drive_srcs();
        k = 0;
        while (n_xfer < 2 && k < 20) begin
            tick();
            sample();
            k++;
        end
        tick();
        bus.out_buffer_full = 1'b1;
        held = exp_q[0];
        for (int c = 0; c < 5; c++) begin
            sample();
            checks++;
            if (bus.out_flit !== held || bus.out_data_ready !== 1'b1 || n_xfer != 2) begin
                fails++;
                $display("FAIL t4_hold c%0d: out_flit=%h ready=%b transfers=%0d, expected %h 1 2",
                         c, bus.out_flit, bus.out_data_ready, n_xfer, held);
            end
            tick();
        end
        bus.out_buffer_full = 1'b0;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            sample();
            tick();
            k++;
        end
        sample();
        checks++;
        if (exp_q.size() != 0 || n_xfer != 6) begin
            fails++;
            $display("FAIL t4_drain: %0d outstanding, %0d transfers, expected 0 and 6", exp_q.size(), n_xfer);
        end
    endtask

    task automatic test_async_reset();
        int unsigned k;
        do_reset();
        push_pkt(1, 4, 32'h1000_0300);
        drive_srcs();
        k = 0;
        while (n_xfer < 2 && k < 20) begin
            tick();
            sample();
            k++;
        end
        tick();
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if (bus.out_data_ready !== 1'b0 || bus.in_buffer_full !== 4'b1111 || bus.busy !== 1'b0 || bus.owner !== 2'd0) begin
            fails++;
            $display("FAIL t5_async: ready=%b in_buffer_full=%b busy=%b owner=%0d, expected 0 1111 0 0",
                     bus.out_data_ready, bus.in_buffer_full, bus.busy, bus.owner);
        end
        clear_all();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        push_pkt(1, 2, 32'h1000_0400);
        drive_srcs();
        for (int c = 0; c < 2; c++) begin
            sample();
            checks++;
            if (bus.busy !== (c == 1) || (c == 1 && bus.owner !== 2'd1)) begin
                fails++;
                $display("FAIL t5_regrant c%0d: busy=%b owner=%0d, expected %b 1", c, bus.busy, bus.owner, (c == 1));
            end
            tick();
        end
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin
            sample();
            tick();
            k++;
        end
        checks++;
        if (exp_q.size() != 0 || n_xfer != 2) begin
            fails++;
            $display("FAIL t5_drain: %0d outstanding, %0d transfers, expected 0 and 2", exp_q.size(), n_xfer);
        end
    endtask

    initial begin
        bus.in_data_ready   = '0;
        bus.in_flit         = '0;
        bus.in_last         = '0;
        bus.out_buffer_full = 1'b0;
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_lock();
        test_backpressure();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
